// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory bus: the master holds mem_req until mem_ack.
// Read data is valid only in the cycle mem_ack pulses.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage controller: byte/half/word loads and stores over a req/ack bus with alignment check and timeout.
// Latency: 2 cycles minimum (accept -> done); stall holds the pipeline from accept until the done cycle.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_valid,
  input  logic              ctrl_memRead,
  input  logic              ctrl_memWrite,
  input  logic [5:0]        opcode,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  mem_access_unit_if.master mem,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              stall,
  output logic              err_align,
  output logic              err_bus
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [5:0]  op_q;
  logic [1:0]  lane_q;

  logic        is_load_op, is_store_op, is_half, is_word;
  logic        accept, acc_err;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  always_comb begin
    is_load_op  = 1'b0;
    is_store_op = 1'b0;
    is_half     = 1'b0;
    is_word     = 1'b0;
    case (opcode)
      OP_LB, OP_LBU: is_load_op = 1'b1;
      OP_LH, OP_LHU: begin is_load_op = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load_op = 1'b1; is_word = 1'b1; end
      OP_SB:         is_store_op = 1'b1;
      OP_SH:         begin is_store_op = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store_op = 1'b1; is_word = 1'b1; end
      default:       ;
    endcase
  end

  assign accept  = (state == IDLE) && acc_valid && (ctrl_memRead || ctrl_memWrite);
  // Any malformed request completes without touching the bus.
  assign acc_err = (ctrl_memRead && ctrl_memWrite)
                 || !(is_load_op || is_store_op)
                 || (ctrl_memRead && !is_load_op)
                 || (ctrl_memWrite && !is_store_op)
                 || (is_half && addr[0])
                 || (is_word && (addr[1:0] != 2'b00));

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = 32'h0;
    if (ctrl_memWrite) begin
      case (opcode)
        OP_SH: begin
          be_n    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{store_data[15:0]}};
        end
        OP_SB: begin
          be_n    = 4'b0001 << addr[1:0];
          wdata_n = {4{store_data[7:0]}};
        end
        default: wdata_n = store_data;
      endcase
    end
  end

  function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] lane,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      OP_LW:   return w;
      default: return 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = acc_err ? DONE : BUSY;
      BUSY:    if (mem.mem_ack || (cnt == TO_LAST)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= 8'h0;
      op_q          <= 6'h0;
      lane_q        <= 2'b00;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_be    <= 4'h0;
      mem.mem_wdata <= 32'h0;
      load_data     <= 32'h0;
      err_align     <= 1'b0;
      err_bus       <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= opcode;
        lane_q    <= addr[1:0];
        cnt       <= 8'h0;
        load_data <= 32'h0;
        err_align <= acc_err;
        err_bus   <= 1'b0;
        if (!acc_err) begin
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= ctrl_memWrite;
          mem.mem_addr  <= {addr[31:2], 2'b00};
          mem.mem_be    <= be_n;
          mem.mem_wdata <= wdata_n;
        end
      end
      if (state == BUSY) begin
        if (mem.mem_ack) begin
          mem.mem_req <= 1'b0;
          if (!mem.mem_we) load_data <= extract(op_q, lane_q, mem.mem_rdata);
        end else if (cnt == TO_LAST) begin
          mem.mem_req <= 1'b0;
          err_bus     <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign done  = (state == DONE);
  assign stall = accept || (state == BUSY);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected bus requests and completions,
// independent monitors pop and compare when the DUT raises mem_req or done.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        acc_valid = 1'b0;
  logic        ctrl_memRead = 1'b0;
  logic        ctrl_memWrite = 1'b0;
  logic [5:0]  opcode = 6'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] load_data;
  logic        done, stall, err_align, err_bus;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .acc_valid     (acc_valid),
    .ctrl_memRead  (ctrl_memRead),
    .ctrl_memWrite (ctrl_memWrite),
    .opcode        (opcode),
    .addr          (addr),
    .store_data    (store_data),
    .mem           (bus),
    .load_data     (load_data),
    .done          (done),
    .stall         (stall),
    .err_align     (err_align),
    .err_bus       (err_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ea;
    logic        eb;
  } done_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : done_mon
    done_t e;
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = done_q.pop_front();
        check("load_data", load_data, e.data);
        check("err_align", {31'h0, err_align}, {31'h0, e.ea});
        check("err_bus", {31'h0, err_bus}, {31'h0, e.eb});
      end
    end
  end

  always @(negedge clk) begin : bus_mon
    bus_t e;
    if (bus.mem_req && !req_prev) begin
      if (bus_q.size() == 0) begin
        check("unexpected_mem_req", 32'd1, 32'd0);
      end else begin
        e = bus_q.pop_front();
        check("mem_we", {31'h0, bus.mem_we}, {31'h0, e.we});
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_be", {28'h0, bus.mem_be}, {28'h0, e.be});
        if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
      end
    end
    req_prev <= bus.mem_req;
  end

  // ack_at: BUSY cycle (1-based) in which mem_ack pulses; 0 means never.
  task automatic access(input logic [5:0] op, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rdat,
                        input int exp_lat, input int exp_req);
    int got_lat, stall_cnt, req_cnt;
    got_lat = 0; stall_cnt = 1; req_cnt = 0;
    @(posedge clk); #1;
    acc_valid = 1'b1; ctrl_memRead = rd; ctrl_memWrite = wr;
    opcode = op; addr = a; store_data = sd;
    @(negedge clk);
    check("stall_on_accept", {31'h0, stall}, 32'd1);
    @(posedge clk); #1;
    acc_valid = 1'b0; ctrl_memRead = 1'b0; ctrl_memWrite = 1'b0;
    opcode = 6'h0; addr = 32'h0; store_data = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      bus.mem_ack   = (c == ack_at);
      bus.mem_rdata = (c == ack_at) ? rdat : 32'h0;
      @(negedge clk);
      if (bus.mem_req) req_cnt++;
      if (done) begin
        got_lat = c;
        check("stall_in_done", {31'h0, stall}, 32'd0);
        bus.mem_ack = 1'b0;
        break;
      end
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
    end
    check("done_latency", got_lat, exp_lat);
    check("stall_cycles", stall_cnt, exp_lat);
    check("mem_req_cycles", req_cnt, exp_req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'd0);
    check("rst_stall", {31'h0, stall}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_errs", {30'h0, err_align, err_bus}, 32'h0);

    // acc_valid without any ctrl bit is not an access
    @(posedge clk); #1;
    acc_valid = 1'b1; opcode = 6'h23; addr = 32'h100;
    @(negedge clk);
    check("idle_no_ctrl_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    acc_valid = 1'b0;
    @(negedge clk);
    check("idle_no_ctrl_req", {30'h0, bus.mem_req, done}, 32'h0);

    // lw, ack on first BUSY cycle
    bus_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0});
    done_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
    access(6'h23, 1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 2, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'd0);
    check("load_data_hold", load_data, 32'hDEADBEEF);

    // lh / lhu upper half, back-to-back after DONE
    bus_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0});
    done_q.push_back('{32'hFFFF8001, 1'b0, 1'b0});
    access(6'h21, 1'b1, 1'b0, 32'h102, 32'h0, 2, 32'h80011234, 3, 2);
    bus_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0});
    done_q.push_back('{32'h00008001, 1'b0, 1'b0});
    access(6'h25, 1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h80011234, 2, 1);

    // lb sign extension from lane 1
    bus_q.push_back('{1'b0, 32'h10, 4'hF, 32'h0});
    done_q.push_back('{32'hFFFFFF80, 1'b0, 1'b0});
    access(6'h20, 1'b1, 1'b0, 32'h11, 32'h0, 1, 32'h00008000, 2, 1);

    // stores: sb lane 3, sh upper half
    bus_q.push_back('{1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5});
    done_q.push_back('{32'h0, 1'b0, 1'b0});
    access(6'h28, 1'b0, 1'b1, 32'h203, 32'h000000A5, 1, 32'h0, 2, 1);
    bus_q.push_back('{1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF});
    done_q.push_back('{32'h0, 1'b0, 1'b0});
    access(6'h29, 1'b0, 1'b1, 32'h202, 32'h1234BEEF, 3, 32'h0, 4, 3);

    // error paths: misaligned lw, both ctrl bits, store opcode with memRead, unknown opcode
    done_q.push_back('{32'h0, 1'b1, 1'b0});
    access(6'h23, 1'b1, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1, 0);
    done_q.push_back('{32'h0, 1'b1, 1'b0});
    access(6'h23, 1'b1, 1'b1, 32'h100, 32'h0, 0, 32'h0, 1, 0);
    done_q.push_back('{32'h0, 1'b1, 1'b0});
    access(6'h2B, 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1, 0);
    done_q.push_back('{32'h0, 1'b1, 1'b0});
    access(6'h22, 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1, 0);

    // timeout (TIMEOUT=4), then a late ack two cycles after DONE
    bus_q.push_back('{1'b0, 32'h300, 4'hF, 32'h0});
    done_q.push_back('{32'h0, 1'b0, 1'b1});
    access(6'h23, 1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0, 5, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("late_ack_done", {31'h0, done}, 32'd0);
    check("late_ack_stall", {30'h0, stall, bus.mem_req}, 32'h0);
    check("late_ack_errbus_hold", {31'h0, err_bus}, 32'd1);
    check("late_ack_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;

    // async reset during BUSY of sw
    bus_q.push_back('{1'b1, 32'h40, 4'hF, 32'h11223344});
    @(posedge clk); #1;
    acc_valid = 1'b1; ctrl_memWrite = 1'b1; opcode = 6'h2B; addr = 32'h40; store_data = 32'h11223344;
    @(posedge clk); #1;
    acc_valid = 1'b0; ctrl_memWrite = 1'b0; opcode = 6'h0; addr = 32'h0; store_data = 32'h0;
    @(posedge clk); #1;
    check("sw_busy_req", {30'h0, bus.mem_req, stall}, 32'h3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", {31'h0, bus.mem_req}, 32'd0);
    check("async_rst_stall", {31'h0, stall}, 32'd0);
    check("async_rst_done", {31'h0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("post_rst_ack_ignored", {30'h0, done, stall}, 32'h0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;

    // lbu lane 3 zero extension
    bus_q.push_back('{1'b0, 32'h0, 4'hF, 32'h0});
    done_q.push_back('{32'h00000080, 1'b0, 1'b0});
    access(6'h24, 1'b1, 1'b0, 32'h3, 32'h0, 1, 32'h80000000, 2, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_q_drained", done_q.size(), 32'd0);
    check("bus_q_drained", bus_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential memory-stage controller that consumes the datapath control word (`ctrl_memRead`, `ctrl_memWrite`) and opcode, and drives a request/acknowledge data-memory bus. It performs word, halfword and byte loads and stores with lane steering, sign or zero extension, alignment checking and a bus timeout. While an access is outstanding it asserts `stall` to freeze the pipeline.

## Interface
- `TIMEOUT`, 16: BUSY cycles without `mem_ack` before aborting; legal range 2..255.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `acc_valid`  in  1  pipeline presents a memory-stage instruction this cycle.
- `ctrl_memRead`  in  1  load request from main control.
- `ctrl_memWrite`  in  1  store request from main control.
- `opcode`  in  6  instruction opcode: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
- `addr`  in  32  byte address from ALU.
- `store_data`  in  32  rt value for stores.
- `mem_req`  out  1  bus request; held until `mem_ack` or timeout.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables, bit 0 = byte at offset 0 (little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  bus completion, one-cycle pulse; `mem_rdata` valid in same cycle.
- `mem_rdata`  in  32  read data word.
- `load_data`  out  32  extended load result, valid while `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `stall`  out  1  pipeline must hold.
- `err_align`  out  1  with `done`: misaligned address or illegal opcode.
- `err_bus`  out  1  with `done`: timeout expired.

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE; all outputs 0, counter 0.
- Accept in IDLE when `acc_valid` & (`ctrl_memRead` | `ctrl_memWrite`). Otherwise stay in IDLE, no stall.
- On accept, latch opcode, addr, store_data, direction.
- Error check at accept: both ctrl bits set, opcode not in table, opcode direction disagreeing with ctrl bit, halfword with addr[0]=1, or word with addr[1:0]≠0 -> go to DONE with `err_align`=1; no bus request issued.
- Otherwise go to BUSY: `mem_req`=1, `mem_we`=store, counter cleared.
- Store lanes: sw be=1111, wdata=data; sh be=0011 (addr[1]=0) or 1100, wdata={2{data[15:0]}}; sb be=0001<<addr[1:0], wdata={4{data[7:0]}}. Loads: be=1111.
- Load extraction: byte select by addr[1:0], half select by addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass through. Result registered on ack.
- BUSY + `mem_ack` -> DONE (counter ignored). BUSY, no ack, counter = TIMEOUT-1 -> DONE with `err_bus`=1, `load_data`=0. Otherwise counter +1 (8-bit, cannot wrap because of cap).
- DONE: `done`=1 for exactly one cycle, -> IDLE. `load_data` and error flags hold until the next accept; `done` clears.
- `mem_ack` outside BUSY is ignored.
- Stores leave `load_data` at 0.

## Timing
- `stall` = (IDLE & accept) | BUSY. It is combinational on the accept cycle and deasserted in DONE so the pipeline advances at the end of the DONE cycle.
- All bus outputs are registered. With accept at cycle N: `mem_req` rises N+1. With ack at N+1, DONE occurs at N+2. Minimum latency is 2 cycles; stall is high in cycles N and N+1.
- Ack after k BUSY cycles puts DONE at N+1+k. Timeout puts DONE at N+1+TIMEOUT, and `mem_req` falls the same edge.
- Error path: DONE at N+1, `mem_req` never asserted, stall high only in cycle N.
- New accept is possible the cycle after DONE; no back-to-back accept in DONE.
- Async `reset` mid-BUSY drops `mem_req`, `stall`, `done` immediately and returns to IDLE. Late acks are ignored.

## Test plan
- lw, addr 0x100, ack on first BUSY cycle with rdata 0xDEADBEEF: mem_addr 0x100, be 1111, done at N+2 with load_data 0xDEADBEEF, stall high exactly 2 cycles.
- lh addr 0x102 and lhu addr 0x102, rdata 0x8001_1234: load_data 0xFFFF8001 and 0x00008001 respectively.
- sb addr 0x203, store_data 0x000000A5: mem_we=1, mem_addr 0x200, be 1000, wdata 0xA5A5A5A5. sh addr 0x202: be 1100.
- lw addr 0x101: done at N+1 with err_align=1, mem_req never high. ctrl_memRead=ctrl_memWrite=1 gives the same result.
- TIMEOUT=4, no ack: mem_req high 4 cycles, done at N+5 with err_bus=1, load_data 0. An ack 2 cycles later is ignored.
- reset pulsed during BUSY of sw: mem_req and stall go 0 asynchronously, no done. A following lbu addr 0x3, rdata 0x80000000 gives load_data 0x00000080.
